// File: rtl/result_trace_capture.sv
// result_trace_capture: triggered trace buffer for ALU result samples.
// Samples are captured into a circular buffer while armed; a selectable trigger
// starts a post-trigger window, after which the buffer is read out oldest-first
// through a valid/ready port. The buffer keeps the most recent DEPTH samples.
module result_trace_capture #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_valid,
    input  logic [DATA_W-1:0]          result,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       zero,
    input  logic                       lt,
    input  logic                       ltu,
    input  logic                       arm,
    input  logic [1:0]                 trig_mode,
    input  logic [DATA_W-1:0]          match_val,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [2*DATA_W+2:0]        rd_data,
    output logic [1:0]                 state,
    output logic                       triggered,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = AW + 1;
    localparam int ENTRY_W = 2 * DATA_W + 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Registered state and its next-state values.
    state_t          state_q,    state_d;
    logic [AW-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [AW-1:0]   post_cnt_q, post_cnt_d;
    logic [CW-1:0]   count_q,    count_d;
    logic            overflow_q, overflow_d;

    // Trace storage: one entry per accepted sample.
    logic [ENTRY_W-1:0] mem [DEPTH];

    logic               capturing;
    logic               accept;
    logic               trig_hit;
    logic               buf_full;
    logic               enter_done;
    logic [ENTRY_W-1:0] wr_entry;

    // Samples only land in the buffer while a capture is in progress.
    assign capturing = (state_q == S_ARMED) || (state_q == S_POST);
    assign accept    = sample_valid && capturing;
    assign buf_full  = (count_q == CW'(DEPTH));
    assign wr_entry  = {ltu, lt, zero, wdata, result};

    // Trigger condition on the sample presented this cycle; it is only acted
    // on when that sample is also accepted.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise a path that skips the assignment infers a latch.
        trig_hit = 1'b0;
        unique case (trig_mode)
            2'd0:    trig_hit = 1'b1;
            2'd1:    trig_hit = zero;
            2'd2:    trig_hit = (result == match_val);
            2'd3:    trig_hit = lt | ltu;
            default: trig_hit = 1'b0;
        endcase
    end

    // Next-state logic: capture bookkeeping, trigger window and readout pops.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        post_cnt_d = post_cnt_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        enter_done = 1'b0;

        // Every accepted sample advances the write pointer; once the buffer
        // is full the oldest entry is overwritten instead of growing count.
        if (accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (buf_full) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d    = S_ARMED;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    count_d    = '0;
                    overflow_d = 1'b0;
                    post_cnt_d = '0;
                end
            end

            S_ARMED: begin
                // The trigger sample itself is stored; the window that follows
                // holds POST_TRIG further accepted samples.
                if (accept && trig_hit) begin
                    post_cnt_d = AW'(POST_TRIG);
                    if (POST_TRIG == 0) begin
                        state_d    = S_DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_d = S_POST;
                    end
                end
            end

            S_POST: begin
                // Gaps in sample_valid do not consume the window.
                if (accept) begin
                    post_cnt_d = post_cnt_q - AW'(1);
                    if (post_cnt_q == AW'(1)) begin
                        state_d    = S_DONE;
                        enter_done = 1'b1;
                    end
                end
            end

            S_DONE: begin
                // A re-arm abandons the readout and wins over a pop.
                if (arm) begin
                    state_d    = S_ARMED;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    count_d    = '0;
                    overflow_d = 1'b0;
                    post_cnt_d = '0;
                end else if (count_q == '0) begin
                    state_d = S_IDLE;
                end else if (rd_ready) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    count_d  = count_q - CW'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Readout starts at the oldest surviving entry. With a full buffer
        // count truncates to zero and the oldest entry is at the write pointer.
        if (enter_done) begin
            rd_ptr_d = wr_ptr_d - count_d[AW-1:0];
        end
    end

    // State register with asynchronous reset; captured data is discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: registers use non-blocking assignments so every flop
            // samples the pre-edge values, independent of statement order.
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            post_cnt_q <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            post_cnt_q <= post_cnt_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Buffer write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; count gates every
        // read, so stale contents are never presented as valid.
        if (accept) begin
            mem[wr_ptr_q] <= wr_entry;
        end
    end

    // Output view of the internal state.
    assign state     = state_q;
    assign triggered = (state_q == S_POST) || (state_q == S_DONE);
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign rd_valid  = (state_q == S_DONE) && (count_q != '0);
    assign rd_data   = mem[rd_ptr_q];

    // Structural invariants of the buffer bookkeeping.
    assert property (@(posedge clk) disable iff (rst) count_q <= CW'(DEPTH))
        else $error("count exceeds buffer depth");
    assert property (@(posedge clk) disable iff (rst) rd_valid |-> (state_q == S_DONE))
        else $error("rd_valid outside readout");

endmodule

// File: tb/tb_result_trace_capture.sv
// Testbench for result_trace_capture: directed scenarios plus a randomized run,
// checked against a queue-based reference model through a readout scoreboard.
module tb_result_trace_capture;

    localparam int DATA_W    = 32;
    localparam int DEPTH     = 8;
    localparam int POST_TRIG = 4;
    localparam int ENTRY_W   = 2 * DATA_W + 3;
    localparam int CW        = $clog2(DEPTH) + 1;

    typedef logic [ENTRY_W-1:0] entry_t;

    logic                 clk;
    logic                 rst;
    logic                 sample_valid;
    logic [DATA_W-1:0]    result;
    logic [DATA_W-1:0]    wdata;
    logic                 zero;
    logic                 lt;
    logic                 ltu;
    logic                 arm;
    logic [1:0]           trig_mode;
    logic [DATA_W-1:0]    match_val;
    logic                 rd_ready;
    logic                 rd_valid;
    logic [ENTRY_W-1:0]   rd_data;
    logic [1:0]           state;
    logic                 triggered;
    logic [CW-1:0]        count;
    logic                 overflow;

    result_trace_capture #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .POST_TRIG (POST_TRIG)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .result       (result),
        .wdata        (wdata),
        .zero         (zero),
        .lt           (lt),
        .ltu          (ltu),
        .arm          (arm),
        .trig_mode    (trig_mode),
        .match_val    (match_val),
        .rd_ready     (rd_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .state        (state),
        .triggered    (triggered),
        .count        (count),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: expected readout entries, and what the DUT actually handed over.
    entry_t exp_q[$];
    entry_t got_q[$];

    // Reference model: 0 idle, 1 armed, 2 post, 3 done.
    int     m_state     = 0;
    entry_t m_buf[$];
    int     m_count     = 0;
    bit     m_ovf       = 1'b0;
    int     m_remaining = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit trig_cond();
        case (trig_mode)
            2'd0:    return 1'b1;
            2'd1:    return zero;
            2'd2:    return result == match_val;
            default: return lt | ltu;
        endcase
    endfunction

    function automatic int model_count();
        if (m_state == 1 || m_state == 2) return m_buf.size();
        return m_count;
    endfunction

    task automatic model_enter_done();
        m_state = 3;
        m_count = m_buf.size();
        foreach (m_buf[i]) exp_q.push_back(m_buf[i]);
        m_buf.delete();
    endtask

    task automatic model_rearm();
        m_state = 1;
        m_buf.delete();
        m_count = 0;
        m_ovf   = 1'b0;
        exp_q.delete();
    endtask

    // Model step on each clock edge or reset assertion.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_state = 0;
                m_buf.delete();
                m_count = 0;
                m_ovf   = 1'b0;
                exp_q.delete();
            end else begin
                case (m_state)
                    0: if (arm) model_rearm();
                    1, 2: begin
                        if (sample_valid) begin
                            m_buf.push_back({ltu, lt, zero, wdata, result});
                            if (m_buf.size() > DEPTH) begin
                                void'(m_buf.pop_front());
                                m_ovf = 1'b1;
                            end
                            if (m_state == 1) begin
                                if (trig_cond()) begin
                                    m_remaining = POST_TRIG;
                                    if (m_remaining == 0) model_enter_done();
                                    else m_state = 2;
                                end
                            end else begin
                                m_remaining--;
                                if (m_remaining == 0) model_enter_done();
                            end
                        end
                    end
                    default: begin
                        if (arm) model_rearm();
                        else if (m_count == 0) m_state = 0;
                        else if (rd_ready) m_count--;
                    end
                endcase
            end
        end
    end

    // Monitor: compares status every cycle and readout entries as presented.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("state", state, m_state);
                check("count", count, model_count());
                check("overflow", overflow, m_ovf);
                check("triggered", triggered, m_state >= 2);
                check("rd_valid", rd_valid, (m_state == 3) && (m_count != 0));
                if (rd_valid) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL rd_unexpected: got 0x%0h expected no entry at %0t", rd_data, $time);
                    end else begin
                        check("rd_data", rd_data, exp_q[0]);
                        if (rd_ready && !arm) begin
                            got_q.push_back(rd_data);
                            void'(exp_q.pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        sample_valid = 1'b0;
        arm          = 1'b0;
        rd_ready     = 1'b0;
        zero         = 1'b0;
        lt           = 1'b0;
        ltu          = 1'b0;
        result       = '0;
        wdata        = '0;
    endtask

    task automatic pulse_arm(input logic [1:0] mode, input logic [DATA_W-1:0] mv);
        trig_mode = mode;
        match_val = mv;
        arm       = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic send(input logic [DATA_W-1:0] res, input logic z, input logic l, input logic lu);
        sample_valid = 1'b1;
        result       = res;
        wdata        = $urandom;
        zero         = z;
        lt           = l;
        ltu          = lu;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        rd_ready = 1'b1;
        while (state != 2'd0 && k < 64) begin
            tick();
            k++;
        end
        if (state != 2'd0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: state 0x%0h expected 0x0 after %0d cycles", state, k);
        end
        rd_ready = 1'b0;
        check("drained", exp_q.size(), 0);
    endtask

    initial begin
        rst       = 1'b1;
        trig_mode = 2'd0;
        match_val = '0;
        idle_inputs();
        repeat (3) tick();
        check("rst_state", state, 0);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_triggered", triggered, 0);
        check("rst_rd_valid", rd_valid, 0);
        rst = 1'b0;
        tick();

        // Immediate trigger: five samples captured, readout stalled then drained.
        got_q.delete();
        pulse_arm(2'd0, '0);
        for (int i = 1; i <= 8; i++) send(i, 1'($urandom), 1'($urandom), 1'($urandom));
        for (int i = 0; i < 3; i++) begin
            check("a_stall_data", rd_data[DATA_W-1:0], 1);
            check("a_stall_count", count, 5);
            tick();
        end
        check("a_overflow", overflow, 0);
        drain();
        check("a_readout_len", got_q.size(), 5);
        foreach (got_q[i]) check("a_readout_val", got_q[i][DATA_W-1:0], i + 1);

        // Match trigger at 0x10: window wraps the buffer, oldest entries lost.
        got_q.delete();
        pulse_arm(2'd2, 32'h10);
        for (int i = 1; i <= 32; i++) send(i, 1'($urandom), 1'($urandom), 1'($urandom));
        check("b_overflow", overflow, 1);
        drain();
        check("b_readout_len", got_q.size(), 8);
        foreach (got_q[i]) check("b_readout_val", got_q[i][DATA_W-1:0], 32'h0D + i);

        // lt trigger on the third sample, gapped samples after it.
        got_q.delete();
        pulse_arm(2'd3, '0);
        for (int i = 1; i <= 10; i++) begin
            if (i > 3) tick();
            send(i, 1'($urandom), i == 3, 1'b0);
            if (i == 6) check("c_still_post", state, 2);
            if (i == 7) check("c_done", state, 3);
        end
        drain();
        check("c_readout_len", got_q.size(), 7);
        if (got_q.size() == 7) begin
            check("c_trig_flags", got_q[2][ENTRY_W-1:ENTRY_W-2], 2'b01);
            check("c_last_val", got_q[6][DATA_W-1:0], 7);
        end

        // Asynchronous reset in the middle of a post-trigger window.
        pulse_arm(2'd1, '0);
        for (int i = 1; i <= 10; i++) send(i, 1'b0, 1'b0, 1'b0);
        send(11, 1'b1, 1'b0, 1'b0);
        send(12, 1'b0, 1'b0, 1'b0);
        check("d_in_post", state, 2);
        check("d_overflow_set", overflow, 1);
        #3;
        rst = 1'b1;
        #1;
        check("d_rst_state", state, 0);
        check("d_rst_count", count, 0);
        check("d_rst_overflow", overflow, 0);
        check("d_rst_triggered", triggered, 0);
        check("d_rst_rd_valid", rd_valid, 0);
        tick();
        rst = 1'b0;
        tick();

        // Re-arm during readout wins over a same-cycle pop.
        got_q.delete();
        pulse_arm(2'd0, '0);
        for (int i = 1; i <= 5; i++) send(i, 1'b0, 1'b0, 1'b0);
        rd_ready = 1'b1;
        arm      = 1'b1;
        tick();
        arm      = 1'b0;
        rd_ready = 1'b0;
        check("e_rearm_state", state, 1);
        check("e_rearm_count", count, 0);
        check("e_no_pop", got_q.size(), 0);
        for (int i = 1; i <= 5; i++) send(i, 1'b0, 1'b0, 1'b0);
        drain();

        // Randomized traffic against the reference model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            sample_valid = ($urandom_range(0, 3) != 0);
            result       = $urandom_range(0, 15);
            wdata        = $urandom;
            zero         = ($urandom_range(0, 7) == 0);
            lt           = ($urandom_range(0, 9) == 0);
            ltu          = ($urandom_range(0, 9) == 0);
            arm          = ($urandom_range(0, 24) == 0);
            trig_mode    = 2'($urandom_range(0, 3));
            match_val    = $urandom_range(0, 15);
            rd_ready     = ($urandom_range(0, 1) == 1);
            tick();
        end
        idle_inputs();
        trig_mode = 2'd0;
        for (int i = 0; i < 6; i++) send(i, 1'b0, 1'b0, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/result_trace_capture.md
RESULT_TRACE_CAPTURE -- requirements
Module: result_trace_capture

Interface
REQ-001 Parameter DATA_W, default 32: width of the result and write-data fields.
REQ-002 Parameter DEPTH, default 16: buffer entries; power of two, >=4.
REQ-003 Parameter POST_TRIG, default 8: samples captured after the trigger sample; range 0..DEPTH-1.
REQ-004 Clocking: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 sample_valid  in  1  the current sample is valid.
REQ-008 result  in  DATA_W  ALU result sample.
REQ-009 wdata  in  DATA_W  write-data sample.
REQ-010 zero, lt, ltu  in  1 each  ALU flag samples.
REQ-011 arm  in  1  single-cycle pulse that starts a capture.
REQ-012 trig_mode  in  2  trigger select: 0 immediate; 1 zero==1; 2 result==match_val; 3 lt|ltu.
REQ-013 match_val  in  DATA_W  compare value for mode 2.
REQ-014 rd_ready  in  1  readout consumer ready.
REQ-015 rd_valid  out  1  rd_data holds a valid entry.
REQ-016 rd_data  out  2*DATA_W+3  entry as {ltu,lt,zero,wdata,result}.
REQ-017 state  out  2  current state: 0 IDLE, 1 ARMED, 2 POST, 3 DONE.
REQ-018 triggered  out  1  high in POST and in DONE.
REQ-019 count  out  clog2(DEPTH)+1  number of valid entries held.
REQ-020 overflow  out  1  sticky flag: the oldest entry was overwritten since the last arm.

Function
REQ-021 A sample is accepted on a rising edge where sample_valid=1 and the state is ARMED or POST; the sample is otherwise ignored.
REQ-022 IDLE: arm=1 -> ARMED; this clears count, pointers and overflow.
REQ-023 ARMED/POST write: each accepted sample is written at wr_ptr; wr_ptr increments modulo DEPTH; count saturates at DEPTH.
REQ-024 A write while count==DEPTH overwrites the oldest entry and sets overflow.
REQ-025 ARMED: an accepted sample that meets the trigger condition is stored and loads post_cnt=POST_TRIG; the next state is POST, or DONE if POST_TRIG=0.
REQ-026 The trigger is evaluated combinationally on the sample being accepted; a non-accepted cycle never triggers.
REQ-027 POST: each accepted sample decrements post_cnt; the write that takes post_cnt to 0 moves the state to DONE.
REQ-028 Entry into DONE sets rd_ptr = (wr_ptr - count) mod DEPTH, so readout starts with the oldest entry.
REQ-029 DONE: rd_valid = (count != 0); rd_data = mem[rd_ptr].
REQ-030 DONE: rd_valid & rd_ready pops one entry (rd_ptr++ mod DEPTH, count--).
REQ-031 DONE: rd_data stays stable while rd_valid=1 and rd_ready=0.
REQ-032 DONE with count==0 -> IDLE on the next edge.
REQ-033 arm=1 in DONE aborts readout and enters ARMED with count, pointers and overflow cleared; arm takes priority over a same-cycle pop.
REQ-034 arm in ARMED or POST is ignored.
REQ-035 rd_valid is 0 outside DONE.
REQ-036 Trigger timing: trigger to DONE takes POST_TRIG+1 accepted samples, independent of gaps in sample_valid.

Reset
REQ-037 rst=1 immediately, without waiting for a clock edge, forces: state=IDLE, wr_ptr=rd_ptr=0, count=0, post_cnt=0, overflow=0, triggered=0, rd_valid=0.
REQ-038 Buffer memory contents need no reset; rd_data is don't-care while rd_valid=0.
REQ-039 Reset asserted mid-capture or mid-readout discards all captured data.

Verification (DATA_W=32, DEPTH=8, POST_TRIG=4)
REQ-040 Arm, mode 0, result=1,2,3,... one per cycle -> DONE after 5 samples; readout 1,2,3,4,5; count=5; overflow=0.
REQ-041 Arm, mode 2, match_val=0x10, result=1..0x20 -> trigger at 0x10; readout 0x0D..0x14 (8 entries); overflow=1.
REQ-042 Mode 3 with sample_valid toggling every other cycle in POST, lt=1 on the 3rd sample -> DONE after the 7th accepted sample; readout includes the flag bits exactly as sampled.
REQ-043 In DONE, hold rd_ready=0 for 3 cycles -> rd_data and count unchanged; then rd_ready=1 -> one pop per cycle until count=0, then IDLE.
REQ-044 Assert rst asynchronously during POST, and separately arm=1 during DONE with rd_ready=1 -> all outputs at reset values / state=ARMED with count=0 and no pop taken.
